// File: rtl/phy_rx_deframer_pkg.sv
// Shared definitions for the PHY receive deframer: framing symbol codes,
// ordered-set type encodings, framing FSM state encoding and small helpers
// that map between ordered-set symbols and their type codes.
package phy_rx_deframer_pkg;

    localparam logic [7:0] SYM_STP   = 8'hFB;
    localparam logic [7:0] SYM_SDP   = 8'h5C;
    localparam logic [7:0] SYM_END   = 8'hFD;
    localparam logic [7:0] SYM_EDB   = 8'hFE;
    localparam logic [7:0] SYM_SKP   = 8'h1C;
    localparam logic [7:0] SYM_IDL   = 8'h7C;
    localparam logic [7:0] SYM_FTS   = 8'h3C;
    localparam logic [7:0] SYM_COM   = 8'hBC;
    localparam logic [7:0] SYM_LIDLE = 8'h00;

    localparam logic [1:0] OS_SKP = 2'd0;
    localparam logic [1:0] OS_IDL = 2'd1;
    localparam logic [1:0] OS_FTS = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OSET,
        ST_PKT_FIRST,
        ST_PKT
    } state_e;

    // {is_os_symbol, os_type}
    function automatic logic [2:0] os_classify(input logic [7:0] sym);
        case (sym)
            SYM_SKP: return {1'b1, OS_SKP};
            SYM_IDL: return {1'b1, OS_IDL};
            SYM_FTS: return {1'b1, OS_FTS};
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] os_symbol(input logic [1:0] os_type);
        case (os_type)
            OS_IDL:  return SYM_IDL;
            OS_FTS:  return SYM_FTS;
            default: return SYM_SKP;
        endcase
    endfunction

endpackage

// File: rtl/phy_rx_os_detect.sv
// Ordered-set tracker. Started by the framing FSM when a COM is seen in IDLE,
// it counts the following symbols, fixes the set type from the first symbol
// after COM and checks every later symbol against it.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   sym_i, k_i     current symbol and control flag
//   valid_i        symbol qualifier; nothing advances while low
//   start_i        COM accepted in IDLE: begin a new set (count 1)
//   done_o         this symbol completes the set (combinational)
//   type_o         set type, valid with done_o
//   err_o          this symbol breaks the set (combinational)
//   restart_o      the breaking symbol was a COM; a new set starts with it
//   busy_o         a set is in progress
module phy_rx_os_detect
    import phy_rx_deframer_pkg::*;
#(
    parameter int OS_LEN = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] sym_i,
    input  logic       k_i,
    input  logic       valid_i,
    input  logic       start_i,
    output logic       done_o,
    output logic [1:0] type_o,
    output logic       err_o,
    output logic       restart_o,
    output logic       busy_o
);

    localparam int CW = $clog2(OS_LEN + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    type_q, type_d;
    logic [2:0]    cls;
    logic          match;
    logic          last;

    assign cls    = os_classify(sym_i);
    assign busy_o = (cnt_q != '0);

    always_comb begin
        cnt_d     = cnt_q;
        type_d    = type_q;
        done_o    = 1'b0;
        err_o     = 1'b0;
        restart_o = 1'b0;
        type_o    = type_q;
        match     = 1'b0;
        last      = (cnt_q == CW'(OS_LEN - 1));

        // The symbol right after COM selects the type; later ones must repeat it.
        if (cnt_q == CW'(1)) begin
            match  = k_i && cls[2];
            type_o = cls[1:0];
        end else begin
            match = k_i && (sym_i == os_symbol(type_q));
        end

        if (start_i) begin
            cnt_d = CW'(1);
        end else if (valid_i && busy_o) begin
            if (match) begin
                type_d = type_o;
                if (last) begin
                    done_o = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                err_o = 1'b1;
                if (k_i && (sym_i == SYM_COM)) begin
                    restart_o = 1'b1;
                    cnt_d     = CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            type_q <= OS_SKP;
        end else begin
            cnt_q  <= cnt_d;
            type_q <= type_d;
        end
    end

endmodule

// File: rtl/phy_rx_deframer.sv
// Receive deframer downstream of the PHY symbol mux. Recognises COM-led
// ordered sets and STP/SDP-framed packets; delivers payload bytes with
// SOP/EOP, packet type, nullify and length to the link layer.
// Ports:
//   CLK, RESET_L            clock, asynchronous active-low reset
//   DATA_IN, K_IN, VALID_IN  incoming symbol, control flag, qualifier
//   PAYLOAD, PAYLOAD_VALID   payload byte and its strobe
//   SOP, EOP                 first / last payload byte of a packet
//   PKT_TYPE                 0 = TLP, 1 = DLLP, held for the packet
//   PKT_NULL, PKT_LEN        with EOP: nullified flag, payload byte count
//   OS_VALID, OS_TYPE        ordered set completed, its type
//   FRAME_ERR                one-cycle framing violation pulse
module phy_rx_deframer
    import phy_rx_deframer_pkg::*;
#(
    parameter int MAX_PKT = 64,
    parameter int LEN_W   = 7,
    parameter int OS_LEN  = 4
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic [7:0]       DATA_IN,
    input  logic             K_IN,
    input  logic             VALID_IN,
    output logic [7:0]       PAYLOAD,
    output logic             PAYLOAD_VALID,
    output logic             SOP,
    output logic             EOP,
    output logic             PKT_TYPE,
    output logic             PKT_NULL,
    output logic [LEN_W-1:0] PKT_LEN,
    output logic             OS_VALID,
    output logic [1:0]       OS_TYPE,
    output logic             FRAME_ERR
);

    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_PKT);

    state_e           state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic             first_q, first_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             type_q, type_d;

    logic [7:0]       payload_q, payload_d;
    logic             pvld_q, pvld_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic             null_q, null_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             osv_q, osv_d;
    logic [1:0]       ost_q, ost_d;
    logic             ferr_q, ferr_d;

    logic             os_start, os_done, os_err, os_restart, os_busy;
    logic [1:0]       os_type;

    phy_rx_os_detect #(.OS_LEN(OS_LEN)) u_os (
        .clk_i     (CLK),
        .rst_ni    (RESET_L),
        .sym_i     (DATA_IN),
        .k_i       (K_IN),
        .valid_i   (VALID_IN),
        .start_i   (os_start),
        .done_o    (os_done),
        .type_o    (os_type),
        .err_o     (os_err),
        .restart_o (os_restart),
        .busy_o    (os_busy)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        first_d   = first_q;
        cnt_d     = cnt_q;
        type_d    = type_q;
        payload_d = '0;
        pvld_d    = 1'b0;
        sop_d     = 1'b0;
        eop_d     = 1'b0;
        null_d    = 1'b0;
        len_d     = '0;
        osv_d     = 1'b0;
        ost_d     = '0;
        ferr_d    = 1'b0;
        os_start  = 1'b0;

        if (VALID_IN) begin
            case (state_q)
                ST_IDLE: begin
                    if (K_IN) begin
                        if (DATA_IN == SYM_COM) begin
                            os_start = 1'b1;
                            state_d  = ST_OSET;
                        end else if ((DATA_IN == SYM_STP) || (DATA_IN == SYM_SDP)) begin
                            type_d  = (DATA_IN == SYM_SDP);
                            state_d = ST_PKT_FIRST;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else if (DATA_IN != SYM_LIDLE) begin
                        ferr_d = 1'b1;
                    end
                end
                ST_OSET: begin
                    if (!os_busy) begin
                        state_d = ST_IDLE;
                    end else if (os_done) begin
                        osv_d   = 1'b1;
                        ost_d   = os_type;
                        state_d = ST_IDLE;
                    end else if (os_err) begin
                        ferr_d  = 1'b1;
                        state_d = os_restart ? ST_OSET : ST_IDLE;
                    end
                end
                ST_PKT_FIRST: begin
                    if (!K_IN) begin
                        hold_d  = DATA_IN;
                        first_d = 1'b1;
                        cnt_d   = LEN_W'(1);
                        state_d = ST_PKT;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_PKT: begin
                    // The held byte is only released once the next symbol
                    // tells us whether it is the last one.
                    if (!K_IN) begin
                        if (cnt_q == MAX_CNT) begin
                            ferr_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            payload_d = hold_q;
                            pvld_d    = 1'b1;
                            sop_d     = first_q;
                            hold_d    = DATA_IN;
                            first_d   = 1'b0;
                            cnt_d     = cnt_q + 1'b1;
                        end
                    end else if ((DATA_IN == SYM_END) || (DATA_IN == SYM_EDB)) begin
                        payload_d = hold_q;
                        pvld_d    = 1'b1;
                        sop_d     = first_q;
                        eop_d     = 1'b1;
                        null_d    = (DATA_IN == SYM_EDB);
                        len_d     = cnt_q;
                        state_d   = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            first_q   <= 1'b0;
            cnt_q     <= '0;
            type_q    <= 1'b0;
            payload_q <= '0;
            pvld_q    <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            null_q    <= 1'b0;
            len_q     <= '0;
            osv_q     <= 1'b0;
            ost_q     <= '0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            first_q   <= first_d;
            cnt_q     <= cnt_d;
            type_q    <= type_d;
            payload_q <= payload_d;
            pvld_q    <= pvld_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            null_q    <= null_d;
            len_q     <= len_d;
            osv_q     <= osv_d;
            ost_q     <= ost_d;
            ferr_q    <= ferr_d;
        end
    end

    assign PAYLOAD       = payload_q;
    assign PAYLOAD_VALID = pvld_q;
    assign SOP           = sop_q;
    assign EOP           = eop_q;
    assign PKT_TYPE      = type_q;
    assign PKT_NULL      = null_q;
    assign PKT_LEN       = len_q;
    assign OS_VALID      = osv_q;
    assign OS_TYPE       = ost_q;
    assign FRAME_ERR     = ferr_q;

endmodule

// File: tb/tb_phy_rx_deframer.sv
module tb_phy_rx_deframer;

    localparam int MAX_PKT = 4;
    localparam int LEN_W   = 7;
    localparam int OS_LEN  = 4;

    localparam logic [7:0] K_STP = 8'hFB, K_SDP = 8'h5C, K_END = 8'hFD, K_EDB = 8'hFE;
    localparam logic [7:0] K_SKP = 8'h1C, K_IDL = 8'h7C, K_FTS = 8'h3C, K_COM = 8'hBC;
    localparam logic [31:0] EV_FERR = 32'h3000_0000;

    logic             CLK = 1'b0;
    logic             RESET_L = 1'b0;
    logic [7:0]       DATA_IN = 8'h00;
    logic             K_IN = 1'b0;
    logic             VALID_IN = 1'b0;
    logic [7:0]       PAYLOAD;
    logic             PAYLOAD_VALID, SOP, EOP, PKT_TYPE, PKT_NULL;
    logic [LEN_W-1:0] PKT_LEN;
    logic             OS_VALID;
    logic [1:0]       OS_TYPE;
    logic             FRAME_ERR;

    phy_rx_deframer #(.MAX_PKT(MAX_PKT), .LEN_W(LEN_W), .OS_LEN(OS_LEN)) dut (
        .CLK(CLK), .RESET_L(RESET_L), .DATA_IN(DATA_IN), .K_IN(K_IN), .VALID_IN(VALID_IN),
        .PAYLOAD(PAYLOAD), .PAYLOAD_VALID(PAYLOAD_VALID), .SOP(SOP), .EOP(EOP),
        .PKT_TYPE(PKT_TYPE), .PKT_NULL(PKT_NULL), .PKT_LEN(PKT_LEN),
        .OS_VALID(OS_VALID), .OS_TYPE(OS_TYPE), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    bit          mon_en = 1'b0;
    bit          stall_en = 1'b0;
    logic        vin_s = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev_pay(input logic [7:0] b, input logic sop, input logic eop,
                                           input logic typ, input logic nul, input logic [6:0] len);
        return {4'h1, 8'h00, sop, eop, typ, nul, 1'b0, len, b};
    endfunction

    function automatic logic [31:0] ev_os(input logic [1:0] t);
        return {4'h2, 26'h0, t};
    endfunction

    function automatic logic [7:0] os_sym(input int t);
        return (t == 1) ? K_IDL : (t == 2) ? K_FTS : K_SKP;
    endfunction

    // Output event monitor: every pulse/strobe becomes one event in order.
    always @(posedge CLK) vin_s = VALID_IN;

    always @(negedge CLK) begin
        if (mon_en) begin
            if (!vin_s)
                check_eq("quiet_stall", {27'h0, PAYLOAD_VALID, SOP, EOP, OS_VALID, FRAME_ERR}, 32'h0);
            if (PAYLOAD_VALID)
                got_q.push_back(ev_pay(PAYLOAD, SOP, EOP, PKT_TYPE, EOP ? PKT_NULL : 1'b0,
                                       EOP ? PKT_LEN : 7'd0));
            if (OS_VALID)  got_q.push_back(ev_os(OS_TYPE));
            if (FRAME_ERR) got_q.push_back(EV_FERR);
        end
    end

    task automatic stall(input int n);
        repeat (n) begin
            @(negedge CLK);
            VALID_IN = 1'b0;
            DATA_IN  = 8'($urandom);
            K_IN     = 1'($urandom);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic k);
        if (stall_en && ($urandom_range(0, 3) == 0)) stall($urandom_range(1, 3));
        @(negedge CLK);
        VALID_IN = 1'b1;
        DATA_IN  = d;
        K_IN     = k;
        @(posedge CLK);
        #1;
    endtask

    task automatic os_good(input int t);
        send(K_COM, 1'b1);
        repeat (OS_LEN - 1) send(os_sym(t), 1'b1);
        exp_q.push_back(ev_os(2'(t)));
    endtask

    task automatic os_bad();
        int t, pos;
        t   = $urandom_range(0, 2);
        pos = $urandom_range(1, OS_LEN - 1);
        send(K_COM, 1'b1);
        for (int i = 1; i < pos; i++) send(os_sym(t), 1'b1);
        if (pos > 1 && $urandom_range(0, 1) == 1) send(os_sym((t + 1 + $urandom_range(0, 1)) % 3), 1'b1);
        else if ($urandom_range(0, 1) == 1) send(K_END, 1'b1);
        else send(8'($urandom), 1'b0);
        exp_q.push_back(EV_FERR);
    endtask

    task automatic os_restart();
        int t1, t2;
        t1 = $urandom_range(0, 2);
        t2 = $urandom_range(0, 2);
        send(K_COM, 1'b1);
        send(os_sym(t1), 1'b1);
        send(K_COM, 1'b1);
        exp_q.push_back(EV_FERR);
        repeat (OS_LEN - 1) send(os_sym(t2), 1'b1);
        exp_q.push_back(ev_os(2'(t2)));
    endtask

    // Packet of n data bytes. n = 0 is an empty packet; n > MAX_PKT overflows
    // on byte MAX_PKT+1, after which the remaining bytes and the terminator
    // are seen as stray IDLE symbols.
    task automatic pkt(input logic typ, input int n, input logic nul);
        logic [7:0] b;
        send(typ ? K_SDP : K_STP, 1'b1);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            send(b, 1'b0);
            if (n <= MAX_PKT)
                exp_q.push_back(ev_pay(b, i == 0, i == n - 1, typ, (i == n - 1) ? nul : 1'b0,
                                       (i == n - 1) ? 7'(n) : 7'd0));
            else if (i < MAX_PKT - 1) exp_q.push_back(ev_pay(b, i == 0, 1'b0, typ, 1'b0, 7'd0));
            else if (i == MAX_PKT) exp_q.push_back(EV_FERR);
            else if (i > MAX_PKT && b != 8'h00) exp_q.push_back(EV_FERR);
        end
        send(nul ? K_EDB : K_END, 1'b1);
        if (n == 0 || n > MAX_PKT) exp_q.push_back(EV_FERR);
    endtask

    task automatic pkt_abort(input logic typ, input int n);
        logic [7:0] b;
        logic [7:0] bad [6];
        bad = '{K_SKP, K_IDL, K_FTS, K_STP, K_SDP, K_COM};
        send(typ ? K_SDP : K_STP, 1'b1);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            send(b, 1'b0);
            if (i < n - 1) exp_q.push_back(ev_pay(b, i == 0, 1'b0, typ, 1'b0, 7'd0));
        end
        send(bad[$urandom_range(0, 5)], 1'b1);
        exp_q.push_back(EV_FERR);
    endtask

    task automatic junk();
        logic [7:0] stray [5];
        stray = '{K_END, K_EDB, K_SKP, K_IDL, K_FTS};
        case ($urandom_range(0, 2))
            0: pkt(1'($urandom), 0, 1'($urandom));
            1: begin send(stray[$urandom_range(0, 4)], 1'b1); exp_q.push_back(EV_FERR); end
            default: begin send(8'($urandom_range(1, 255)), 1'b0); exp_q.push_back(EV_FERR); end
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int kind;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("reset_outputs", {8'h0, PAYLOAD, PAYLOAD_VALID, SOP, EOP, PKT_TYPE, PKT_NULL,
                                   PKT_LEN, OS_VALID, OS_TYPE, FRAME_ERR}, 32'h0);
        @(negedge CLK);
        RESET_L = 1'b1;
        mon_en  = 1'b1;

        // Ordered set of IDL, flagged one cycle after the last symbol
        send(K_COM, 1'b1);
        repeat (2) send(K_IDL, 1'b1);
        check_eq("os_early", {30'h0, OS_VALID, FRAME_ERR}, 32'h0);
        send(K_IDL, 1'b1);
        check_eq("os_idl", {28'h0, OS_VALID, OS_TYPE, FRAME_ERR}, {28'h0, 1'b1, 2'd1, 1'b0});
        exp_q.push_back(ev_os(2'd1));

        // TLP 55 FF 0F
        send(K_STP, 1'b1);
        send(8'h55, 1'b0);
        send(8'hFF, 1'b0);
        check_eq("tlp_b0", {21'h0, PAYLOAD_VALID, SOP, EOP, PAYLOAD}, {21'h0, 3'b110, 8'h55});
        send(8'h0F, 1'b0);
        check_eq("tlp_b1", {21'h0, PAYLOAD_VALID, SOP, EOP, PAYLOAD}, {21'h0, 3'b100, 8'hFF});
        send(K_END, 1'b1);
        check_eq("tlp_eop", {12'h0, PAYLOAD_VALID, SOP, EOP, PKT_TYPE, PKT_NULL, PKT_LEN, PAYLOAD},
                 {12'h0, 5'b10100, 7'd3, 8'h0F});
        exp_q.push_back(ev_pay(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0));
        exp_q.push_back(ev_pay(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0));
        exp_q.push_back(ev_pay(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 7'd3));

        // Nullified single-byte DLLP
        send(K_SDP, 1'b1);
        send(8'hAA, 1'b0);
        send(K_EDB, 1'b1);
        check_eq("dllp_null", {12'h0, PAYLOAD_VALID, SOP, EOP, PKT_TYPE, PKT_NULL, PKT_LEN, PAYLOAD},
                 {12'h0, 5'b11111, 7'd1, 8'hAA});
        exp_q.push_back(ev_pay(8'hAA, 1'b1, 1'b1, 1'b1, 1'b1, 7'd1));

        // Error cases
        send(K_STP, 1'b1);
        send(K_END, 1'b1);
        check_eq("empty_pkt", {30'h0, PAYLOAD_VALID, FRAME_ERR}, 32'h1);
        exp_q.push_back(EV_FERR);
        send(K_COM, 1'b1);
        send(K_SKP, 1'b1);
        send(K_FTS, 1'b1);
        check_eq("os_mismatch", {30'h0, OS_VALID, FRAME_ERR}, 32'h1);
        exp_q.push_back(EV_FERR);
        send(K_STP, 1'b1);
        send(8'h11, 1'b0);
        send(K_SKP, 1'b1);
        check_eq("pkt_abort", {30'h0, PAYLOAD_VALID, FRAME_ERR}, 32'h1);
        exp_q.push_back(EV_FERR);

        // Stall inside a packet
        send(K_STP, 1'b1);
        send(8'h01, 1'b0);
        stall(3);
        send(8'h02, 1'b0);
        check_eq("stall_b0", {21'h0, PAYLOAD_VALID, SOP, EOP, PAYLOAD}, {21'h0, 3'b110, 8'h01});
        send(K_END, 1'b1);
        check_eq("stall_eop", {13'h0, PAYLOAD_VALID, SOP, EOP, PKT_LEN, PAYLOAD},
                 {13'h0, 3'b101, 7'd2, 8'h02});
        exp_q.push_back(ev_pay(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0));
        exp_q.push_back(ev_pay(8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 7'd2));

        // Length limit: 5th byte overflows
        send(K_STP, 1'b1);
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
        check_eq("overflow", {29'h0, PAYLOAD_VALID, EOP, FRAME_ERR}, 32'h1);
        for (int i = 1; i <= 3; i++) exp_q.push_back(ev_pay(8'(i), i == 1, 1'b0, 1'b0, 1'b0, 7'd0));
        exp_q.push_back(EV_FERR);
        send(K_END, 1'b1);
        exp_q.push_back(EV_FERR);

        // Reset in the middle of a DLLP
        send(K_SDP, 1'b1);
        send(8'h12, 1'b0);
        RESET_L = 1'b0;
        stall(2);
        check_eq("mid_reset", {8'h0, PAYLOAD, PAYLOAD_VALID, SOP, EOP, PKT_TYPE, PKT_NULL,
                               PKT_LEN, OS_VALID, OS_TYPE, FRAME_ERR}, 32'h0);
        @(negedge CLK);
        RESET_L = 1'b1;
        send(K_COM, 1'b1);
        repeat (OS_LEN - 1) send(K_SKP, 1'b1);
        check_eq("os_after_reset", {28'h0, OS_VALID, OS_TYPE, FRAME_ERR}, {28'h0, 1'b1, 2'd0, 1'b0});
        exp_q.push_back(ev_os(2'd0));

        // Randomized frame mix with stalls and logical idles
        stall_en = 1'b1;
        for (int f = 0; f < 150; f++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1:    os_good($urandom_range(0, 2));
                2, 3, 4: pkt(1'($urandom), $urandom_range(1, MAX_PKT), 1'($urandom));
                5:       pkt(1'($urandom), $urandom_range(MAX_PKT + 1, MAX_PKT + 3), 1'($urandom));
                6:       pkt_abort(1'($urandom), $urandom_range(1, MAX_PKT));
                7:       os_bad();
                8:       os_restart();
                default: junk();
            endcase
            if ($urandom_range(0, 1) == 1) send(8'h00, 1'b0);
        end
        stall_en = 1'b0;
        stall(6);
        mon_en = 1'b0;

        check_eq("event_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("event%0d", i), got_q[i], exp_q[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
